// File: rtl/multiply_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among four requesters.
// Grants, registers operands for one cycle, then returns the tagged product.
module multiply_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [WIDTH-1:0]   mul_p,
  output logic               rsp_valid,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_p,
  output logic               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state_reg;
  logic [1:0]       ptr_reg;
  logic [1:0]       id_reg;
  logic [3:0]       gnt_reg;
  logic [WIDTH-1:0] mul_a_reg;
  logic [WIDTH-1:0] mul_b_reg;
  logic             rsp_valid_reg;
  logic [1:0]       rsp_id_reg;
  logic [WIDTH-1:0] rsp_p_reg;

  logic [WIDTH-1:0] a_slice [4];
  logic [WIDTH-1:0] b_slice [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First set request searching upward from ptr_reg, wrapping 3 -> 0.
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_reg;
    cand      = ptr_reg;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_reg + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'd0;
      id_reg        <= 2'd0;
      gnt_reg       <= 4'd0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 2'd0;
      rsp_p_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE, RESP: begin
          rsp_valid_reg <= 1'b0;
          if (win_found) begin
            gnt_reg   <= 4'b0001 << win_idx;
            mul_a_reg <= a_slice[win_idx];
            mul_b_reg <= b_slice[win_idx];
            ptr_reg   <= win_idx + 2'd1;
            id_reg    <= win_idx;
            state_reg <= ISSUE;
          end else begin
            gnt_reg   <= 4'd0;
            state_reg <= IDLE;
          end
        end
        ISSUE: begin
          // Multiplier has had the whole cycle to settle on the registered operands.
          gnt_reg       <= 4'd0;
          rsp_p_reg     <= mul_p;
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        default: begin
          gnt_reg       <= 4'd0;
          rsp_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_p     = rsp_p_reg;
  assign busy      = (state_reg == ISSUE);

endmodule

// File: tb/tb_multiply_arbiter.sv
// Directed bench for multiply_arbiter; a behavioural multiply stands in for
// the shared multiplier instance.
module tb_multiply_arbiter;

  localparam int WIDTH = 16;

  logic               clk;
  logic               nReset;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic [3:0]         gnt;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [WIDTH-1:0]   mul_p;
  logic               rsp_valid;
  logic [1:0]         rsp_id;
  logic [WIDTH-1:0]   rsp_p;
  logic               busy;

  int total = 0;
  int bad   = 0;

  multiply_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  // Stand-in for the shared multiplier: low WIDTH bits of the product.
  assign mul_p = mul_a * mul_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rsp_valid) $display("rsp: id=%0d p=0x%04h", rsp_id, rsp_p);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt),       32'h0);
    chk({tag, "_mula"},  32'(mul_a),     32'h0);
    chk({tag, "_mulb"},  32'(mul_b),     32'h0);
    chk({tag, "_vld"},   32'(rsp_valid), 32'h0);
    chk({tag, "_id"},    32'(rsp_id),    32'h0);
    chk({tag, "_p"},     32'(rsp_p),     32'h0);
    chk({tag, "_busy"},  32'(busy),      32'h0);
  endtask

  initial begin
    logic [WIDTH-1:0] rr_exp;
    nReset = 1'b0;
    req    = 4'd0;
    req_a  = '0;
    req_b  = '0;
    #12;
    chk_zero("reset");
    step();
    nReset = 1'b1;

    // Single request on requester 0: 0x25 * 3 = 0x6F
    set_op(0, 16'h0025, 16'h0003);
    req = 4'b0001;
    step();
    chk("single_gnt",  32'(gnt),   32'h1);
    chk("single_mula", 32'(mul_a), 32'h0025);
    chk("single_mulb", 32'(mul_b), 32'h0003);
    chk("single_busy", 32'(busy),  32'h1);
    chk("single_vld0", 32'(rsp_valid), 32'h0);
    req = 4'b0000;
    step();
    chk("single_vld", 32'(rsp_valid), 32'h1);
    chk("single_id",  32'(rsp_id),    32'h0);
    chk("single_p",   32'(rsp_p),     32'h006F);
    chk("single_gnt0", 32'(gnt),      32'h0);
    chk("single_busy0", 32'(busy),    32'h0);
    step();
    chk("idle_vld",   32'(rsp_valid), 32'h0);
    chk("idle_hold_p", 32'(rsp_p),    32'h006F);
    chk("idle_hold_a", 32'(mul_a),    32'h0025);

    // Truncation on requester 2 (ptr now 1)
    set_op(2, 16'h0100, 16'h0100);
    req = 4'b0100;
    step();
    chk("trunc1_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    chk("trunc1_p",  32'(rsp_p),  32'h0000);
    chk("trunc1_id", 32'(rsp_id), 32'h2);
    step();
    set_op(2, 16'h00FF, 16'h0101);
    req = 4'b0100;
    step();
    chk("trunc2_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    chk("trunc2_p",  32'(rsp_p),  32'hFFFF);
    chk("trunc2_id", 32'(rsp_id), 32'h2);
    step();

    // Pointer fairness: ptr is 3 here; grant 3, then 1001 -> 0 before 3
    set_op(3, 16'h0007, 16'h0009);
    set_op(0, 16'h0002, 16'h0005);
    req = 4'b1000;
    step();
    chk("ptr_gnt3", 32'(gnt), 32'h8);
    req = 4'b1001;
    step();
    chk("ptr_id3", 32'(rsp_id), 32'h3);
    chk("ptr_p3",  32'(rsp_p),  32'h003F);
    step();
    chk("ptr_gnt0", 32'(gnt), 32'h1);
    req = 4'b1000;
    step();
    chk("ptr_id0", 32'(rsp_id), 32'h0);
    chk("ptr_p0",  32'(rsp_p),  32'h000A);
    step();
    chk("ptr_gnt3b", 32'(gnt), 32'h8);
    req = 4'b0000;
    step();
    chk("ptr_id3b", 32'(rsp_id), 32'h3);
    step();

    // Round-robin with all four requesting (ptr is 0), back to back
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 2), 16'h0010);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr%0d_gnt", k),  32'(gnt),  32'(4'b0001 << k));
      chk($sformatf("rr%0d_busy", k), 32'(busy), 32'h1);
      req[k] = 1'b0;
      step();
      rr_exp = 16'((k + 2) * 16);
      chk($sformatf("rr%0d_vld", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("rr%0d_id", k),  32'(rsp_id),    32'(k));
      chk($sformatf("rr%0d_p", k),   32'(rsp_p),     32'(rr_exp));
    end
    step();
    chk("rr_end_busy", 32'(busy), 32'h0);

    // Reset mid-operation: grant requester 2 (ptr -> 3), then reset in ISSUE
    set_op(2, 16'h0003, 16'h0003);
    req = 4'b0100;
    step();
    chk("rst_pre_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    nReset = 1'b0;
    #1;
    chk_zero("rst_mid");
    step();
    nReset = 1'b1;
    step();
    chk("rst_no_vld", 32'(rsp_valid), 32'h0);
    // ptr restarted at 0, so 1 beats 3
    set_op(1, 16'h0011, 16'h0002);
    req = 4'b1010;
    step();
    chk("rst_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    chk("rst_id1", 32'(rsp_id), 32'h1);
    chk("rst_p1",  32'(rsp_p),  32'h0022);
    step();

    // Withdraw: requester 1 pulses req while requester 0 is in ISSUE
    req = 4'b0001;
    step();
    chk("wd_gnt0", 32'(gnt), 32'h1);
    req = 4'b0010;
    #2;
    req = 4'b0000;
    step();
    chk("wd_vld",  32'(rsp_valid), 32'h1);
    chk("wd_gntr", 32'(gnt),       32'h0);
    step();
    chk("wd_gnt_idle",  32'(gnt),       32'h0);
    chk("wd_busy_idle", 32'(busy),      32'h0);
    chk("wd_vld_idle",  32'(rsp_valid), 32'h0);
    step();
    chk("wd_gnt_idle2", 32'(gnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
